// File: rtl/weighted_sum_sequencer.sv
// Feeds an N-pair dot product to an M-lane DSP weighted-sum chain in ceil(N/M) chunks.
// The per-chunk chain sums are accumulated, then presented with a threshold fire bit.
module weighted_sum_sequencer #(
    parameter int N        = 32,
    parameter int M        = 16,
    parameter int PIPE_LAT = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16*N-1:0]   x,
    input  logic [16*N-1:0]   w,
    input  logic [47:0]       threshold,
    output logic [16*M-1:0]   chunk_x,
    output logic [16*M-1:0]   chunk_w,
    output logic              chunk_valid,
    input  logic [47:0]       ws_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [47:0]       sum,
    output logic              fire,
    output logic              busy
);

    localparam int C  = (N + M - 1) / M;
    localparam int PW = 16 * C * M;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [PW-1:0]         x_q, w_q;
    logic [47:0]           thr_q;
    logic [47:0]           acc_q, acc_d;
    logic [CW-1:0]         chunk_cnt_q, res_cnt_q;
    logic [PIPE_LAT-1:0]   tok_q, tok_d;
    logic                  tok_out, last_res;
    logic [16*M-1:0]       chunk_x_q, chunk_w_q;
    logic                  chunk_valid_q, in_ready_q, out_valid_q, fire_q, busy_q;
    logic [47:0]           sum_q;

    function automatic logic above_threshold(input logic [47:0] value, input logic [47:0] thr);
        return value > thr;
    endfunction

    always_comb begin
        acc_d    = acc_q + ws_sum;
        tok_d    = PIPE_LAT'({tok_q, chunk_valid_q});
        tok_out  = tok_q[PIPE_LAT-1];
        last_res = tok_out && (res_cnt_q == CW'(C - 1));
    end

    // The token pipe marks which chain outputs belong to issued chunks; anything else is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b1;
            chunk_valid_q <= 1'b0;
            chunk_x_q     <= '0;
            chunk_w_q     <= '0;
            out_valid_q   <= 1'b0;
            sum_q         <= '0;
            fire_q        <= 1'b0;
            busy_q        <= 1'b0;
            acc_q         <= '0;
            chunk_cnt_q   <= '0;
            res_cnt_q     <= '0;
            tok_q         <= '0;
        end else begin
            tok_q <= tok_d;
            if (tok_out) begin
                acc_q     <= acc_d;
                res_cnt_q <= res_cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        // Zero-extend to whole chunks so the padding lanes fall out as zeros.
                        x_q         <= PW'(x);
                        w_q         <= PW'(w);
                        thr_q       <= threshold;
                        acc_q       <= '0;
                        chunk_cnt_q <= '0;
                        res_cnt_q   <= '0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    chunk_x_q     <= x_q[16*M-1:0];
                    chunk_w_q     <= w_q[16*M-1:0];
                    chunk_valid_q <= 1'b1;
                    x_q           <= x_q >> (16 * M);
                    w_q           <= w_q >> (16 * M);
                    chunk_cnt_q   <= chunk_cnt_q + 1'b1;
                    if (chunk_cnt_q == CW'(C - 1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    chunk_valid_q <= 1'b0;
                    chunk_x_q     <= '0;
                    chunk_w_q     <= '0;
                    if (last_res) begin
                        sum_q       <= acc_d;
                        fire_q      <= above_threshold(acc_d, thr_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign chunk_x     = chunk_x_q;
    assign chunk_w     = chunk_w_q;
    assign chunk_valid = chunk_valid_q;
    assign out_valid   = out_valid_q;
    assign sum         = sum_q;
    assign fire        = fire_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_weighted_sum_sequencer.sv
// Scoreboard bench: two sequencers (N=32 and N=20) each driving a behavioural DSP chain model.
module tb_weighted_sum_sequencer;

    localparam int M  = 16;
    localparam int PL = 17;
    localparam int NA = 32;
    localparam int NB = 20;

    typedef struct {
        logic [47:0] s;
        logic        f;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              a_iv, a_ir, a_cv, a_ov, a_or, a_fire, a_busy;
    logic [16*NA-1:0]  a_x, a_w;
    logic [16*M-1:0]   a_cx, a_cw;
    logic [47:0]       a_thr, a_ws, a_sum;
    logic              b_iv, b_ir, b_cv, b_ov, b_or, b_fire, b_busy;
    logic [16*NB-1:0]  b_x, b_w;
    logic [16*M-1:0]   b_cx, b_cw;
    logic [47:0]       b_thr, b_ws, b_sum;

    weighted_sum_sequencer #(.N(NA), .M(M), .PIPE_LAT(PL)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .w(a_w),
        .threshold(a_thr), .chunk_x(a_cx), .chunk_w(a_cw), .chunk_valid(a_cv),
        .ws_sum(a_ws), .out_valid(a_ov), .out_ready(a_or), .sum(a_sum), .fire(a_fire),
        .busy(a_busy));

    weighted_sum_sequencer #(.N(NB), .M(M), .PIPE_LAT(PL)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .w(b_w),
        .threshold(b_thr), .chunk_x(b_cx), .chunk_w(b_cw), .chunk_valid(b_cv),
        .ws_sum(b_ws), .out_valid(b_ov), .out_ready(b_or), .sum(b_sum), .fire(b_fire),
        .busy(b_busy));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [47:0] a_es, b_es;
    logic        a_ef, b_ef;
    logic        force_a = 1'b0;
    logic [47:0] force_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [47:0] dot(input logic [16*M-1:0] cx, input logic [16*M-1:0] cw);
        logic [47:0] s;
        s = '0;
        for (int j = 0; j < M; j++) s += 48'(cx[16*j +: 16]) * 48'(cw[16*j +: 16]);
        return s;
    endfunction

    // Behavioural DSP chains: dot product of the presented chunk, PL cycles later.
    logic [47:0] pa [PL];
    logic [47:0] pb [PL];
    always @(posedge clk) begin
        pa[0] <= dot(a_cx, a_cw);
        pb[0] <= dot(b_cx, b_cw);
        for (int i = 1; i < PL; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign a_ws = force_a ? force_val : pa[PL-1];
    assign b_ws = pb[PL-1];

    // Accept detection pushes expectations; output handshakes pop and compare.
    logic a_prev_ov = 1'b0, b_prev_ov = 1'b0;
    int   a_rise = 0, b_rise = 0, b_ci = 0;
    always @(negedge clk) begin
        exp_t e;
        if (a_iv && a_ir && !rst) qa.push_back('{a_es, a_ef, cyc + 1});
        if (a_ov && !a_prev_ov) a_rise = cyc;
        a_prev_ov = a_ov;
        if (a_ov && a_or && !rst) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_out: sum %0h with nothing pending", a_sum);
            end else begin
                e = qa.pop_front();
                chk("a_sum", a_sum, e.s);
                chk("a_fire", a_fire, e.f);
                chk("a_latency", a_rise - e.t, 20);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_iv && b_ir && !rst) begin
            qb.push_back('{b_es, b_ef, cyc + 1});
            b_ci = 0;
        end
        if (b_cv) begin
            if (b_ci == 0) chk("b_chunk0_lane0", b_cx[15:0], 1);
            if (b_ci == 1) begin
                chk("b_chunk1_lane3_x", b_cx[63:48], 20);
                chk("b_chunk1_pad_x", |b_cx[16*M-1:64], 0);
                chk("b_chunk1_pad_w", |b_cw[16*M-1:64], 0);
            end
            b_ci++;
        end
        if (b_ov && !b_prev_ov) b_rise = cyc;
        b_prev_ov = b_ov;
        if (b_ov && b_or && !rst) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_out: sum %0h with nothing pending", b_sum);
            end else begin
                e = qb.pop_front();
                chk("b_sum", b_sum, e.s);
                chk("b_fire", b_fire, e.f);
                chk("b_latency", b_rise - e.t, 20);
            end
        end
    end

    task automatic a_go();
        int n;
        n = 0;
        a_iv = 1'b1;
        @(negedge clk);
        while (!a_ir && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("a_accept");
        @(posedge clk);
        #1 a_iv = 1'b0;
    endtask

    task automatic a_wait();
        int n;
        n = 0;
        while ((qa.size() != 0 || a_ov) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) fail_now("a_result");
        @(posedge clk);
        #1;
    endtask

    task automatic a_fill(input logic [15:0] xv, input logic [15:0] wv, input logic ramp);
        for (int i = 0; i < NA; i++) begin
            a_x[16*i +: 16] = ramp ? 16'(i) : xv;
            a_w[16*i +: 16] = wv;
        end
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1;
        a_iv = 1'b0; a_or = 1'b1; a_x = '0; a_w = '0; a_thr = '0;
        b_iv = 1'b0; b_or = 1'b1; b_x = '0; b_w = '0; b_thr = '0;
        a_es = '0; a_ef = 1'b0; b_es = '0; b_ef = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", a_ir, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_chunk_valid", a_cv, 0);
        chk("rst_chunk_x", |a_cx, 0);
        chk("rst_sum", a_sum, 0);
        chk("rst_fire", a_fire, 0);
        @(posedge clk);
        #1;

        // All ones: 32 products of 1, threshold just below.
        a_fill(16'd1, 16'd1, 1'b0);
        a_thr = 48'd31; a_es = 48'd32; a_ef = 1'b1;
        a_go();
        a_wait();

        // Full-scale operands: 32 * 0xFFFE0001.
        a_fill(16'hFFFF, 16'hFFFF, 1'b0);
        a_thr = 48'd0; a_es = 48'h1F_FFC0_0020; a_ef = 1'b1;
        a_go();
        a_wait();

        // Forced chain output: two chunks of 0xF000_0000_0000 wrap to 0xE000_0000_0000.
        force_val = 48'hF000_0000_0000;
        force_a = 1'b1;
        a_fill(16'd1, 16'd1, 1'b0);
        a_thr = 48'hF000_0000_0000; a_es = 48'hE000_0000_0000; a_ef = 1'b0;
        a_go();
        a_wait();
        force_a = 1'b0;

        // Backpressure: x[i]=i, w=3 -> 3*496 = 1488.
        a_fill(16'd0, 16'd3, 1'b1);
        a_thr = 48'd2000; a_es = 48'd1488; a_ef = 1'b0;
        a_or = 1'b0;
        a_go();
        n = 0;
        while (!a_ov && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("a_bp_out_valid");
        @(posedge clk);
        #1 a_iv = 1'b1;
        a_fill(16'd7, 16'd7, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_sum", a_sum, 48'd1488);
            chk("bp_fire", a_fire, 0);
            chk("bp_in_ready", a_ir, 0);
            chk("bp_out_valid", a_ov, 1);
        end
        @(posedge clk);
        #1 a_iv = 1'b0;
        a_or = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", a_ir, 1);
        chk("bp_idle_out_valid", a_ov, 0);
        chk("bp_idle_busy", a_busy, 0);
        @(posedge clk);
        #1;

        // Reset during DRAIN, then a new set immediately afterwards.
        a_fill(16'd5, 16'd5, 1'b0);
        a_thr = 48'd0; a_es = 48'd800; a_ef = 1'b1;
        a_go();
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        qa.delete();
        @(negedge clk);
        chk("abort_in_ready", a_ir, 1);
        chk("abort_busy", a_busy, 0);
        chk("abort_out_valid", a_ov, 0);
        chk("abort_chunk_valid", a_cv, 0);
        chk("abort_sum", a_sum, 0);
        @(posedge clk);
        #1;
        a_fill(16'd2, 16'd3, 1'b0);
        a_thr = 48'd100; a_es = 48'd192; a_ef = 1'b1;
        a_go();
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (a_ov) seen++;
        end
        chk("abort_no_early_out", seen, 0);
        a_wait();

        // Back-to-back with in_valid held; sum equals threshold so no fire.
        a_fill(16'd1, 16'd2, 1'b0);
        a_thr = 48'd64; a_es = 48'd64; a_ef = 1'b0;
        a_iv = 1'b1;
        @(negedge clk);
        n = 0;
        @(negedge clk);
        while (!a_ov && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("b2b_first_out");
        @(negedge clk);
        chk("b2b_next_accept", a_ir, 1);
        @(posedge clk);
        #1 a_iv = 1'b0;
        @(negedge clk);
        chk("b2b_second_busy", a_busy, 1);
        a_wait();

        // N=20: x[i]=i+1, w=2 -> 2*210 = 420; chunk 1 lanes 4..15 padded.
        for (int i = 0; i < NB; i++) begin
            b_x[16*i +: 16] = 16'(i + 1);
            b_w[16*i +: 16] = 16'd2;
        end
        b_thr = 48'd419; b_es = 48'd420; b_ef = 1'b1;
        b_iv = 1'b1;
        @(posedge clk);
        #1 b_iv = 1'b0;
        n = 0;
        while ((qb.size() != 0 || b_ov) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) fail_now("b_result");
        chk("b_chunks_seen", b_ci, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
